// File: rtl/y_tap_line_feeder.sv
// y_tap_line_feeder: three-line buffer presenting four vertical taps per sample.
// Define BOTTOM_FLUSH_EN to emit two replicated bottom rows after each frame.
module y_tap_line_feeder #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        tap_0,
  output logic [DATA_W-1:0]        tap_1,
  output logic [DATA_W-1:0]        tap_2,
  output logic [DATA_W-1:0]        tap_3,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

`ifdef BOTTOM_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;
  localparam bit LAST_IN_STREAM = 1'b0;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM} state_t;
  localparam bit LAST_IN_STREAM = 1'b1;
`endif

  state_t state_q, state_d;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        base_q, base_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [CW-1:0]     ocol_q, ocol_d;
  logic [DATA_W-1:0] t0_q, t0_d;
  logic [DATA_W-1:0] t1_q, t1_d;
  logic [DATA_W-1:0] t2_q, t2_d;
  logic [DATA_W-1:0] t3_q, t3_d;
`ifdef BOTTOM_FLUSH_EN
  logic              fsel_q, fsel_d;
  logic              fdone_q, fdone_d;
`endif

  logic [DATA_W-1:0] mem_q [3][IMG_W];

  logic              load_ok;
  logic              in_fire;
  logic              out_fire;
  logic              col_end;
  logic              row_end;
  logic              row0;
  logic [1:0]        slot1;
  logic [1:0]        slot2;
  logic [DATA_W-1:0] l0;
  logic [DATA_W-1:0] l1;
  logic [DATA_W-1:0] l2;

  function automatic logic [1:0] inc3(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  assign load_ok  = !vld_q || out_ready;
  assign in_ready = (state_q == S_STREAM) && load_ok;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_q && out_ready;
  assign col_end  = col_q == CW'(IMG_W - 1);
  assign row_end  = row_q == RW'(IMG_H - 1);
  assign row0     = row_q == '0;

  // Logical L0/L1/L2 live at base, base+1, base+2 (mod 3)
  assign slot1 = inc3(base_q);
  assign slot2 = inc3(slot1);
  assign l0    = mem_q[base_q][col_q];
  assign l1    = mem_q[slot1][col_q];
  assign l2    = mem_q[slot2][col_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    vld_d   = vld_q;
    last_d  = last_q;
    ocol_d  = ocol_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
`ifdef BOTTOM_FLUSH_EN
    fsel_d  = fsel_q;
    fdone_d = fdone_q;
`endif
    if (out_fire) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_STREAM;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end
      end
      S_STREAM: begin
        if (in_fire) begin
          vld_d  = 1'b1;
          ocol_d = col_q;
          // Row 0 taps bypass the buffers, which hold stale data then
          t0_d   = row0 ? in_data : l0;
          t1_d   = row0 ? in_data : l1;
          t2_d   = row0 ? in_data : l2;
          t3_d   = in_data;
          last_d = LAST_IN_STREAM && row_end && col_end;
          if (col_end) begin
            col_d  = '0;
            base_d = slot1;
            if (row_end) begin
              row_d   = '0;
`ifdef BOTTOM_FLUSH_EN
              state_d = S_FLUSH;
              fsel_d  = 1'b0;
              fdone_d = 1'b0;
`else
              state_d = S_IDLE;
`endif
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
`ifdef BOTTOM_FLUSH_EN
      S_FLUSH: begin
        if (fdone_q) begin
          if (out_fire) state_d = S_IDLE;
        end else if (load_ok) begin
          vld_d  = 1'b1;
          ocol_d = col_q;
          t0_d   = fsel_q ? l1 : l0;
          t1_d   = fsel_q ? l2 : l1;
          t2_d   = l2;
          t3_d   = l2;
          last_d = fsel_q && col_end;
          if (col_end) begin
            col_d = '0;
            if (fsel_q) fdone_d = 1'b1;
            else        fsel_d  = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ocol_q  <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
`ifdef BOTTOM_FLUSH_EN
      fsel_q  <= 1'b0;
      fdone_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      ocol_q  <= ocol_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
`ifdef BOTTOM_FLUSH_EN
      fsel_q  <= fsel_d;
      fdone_q <= fdone_d;
`endif
    end
  end

  // Incoming sample lands in the current L0 slot, which becomes L2 at row end
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (row0) begin
        for (int s = 0; s < 3; s++) mem_q[s][col_q] <= in_data;
      end else begin
        mem_q[base_q][col_q] <= in_data;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_last  = last_q;
  assign out_col   = ocol_q;
  assign tap_0     = t0_q;
  assign tap_1     = t1_q;
  assign tap_2     = t2_q;
  assign tap_3     = t3_q;

endmodule
